// File: rtl/regex_char_feeder.sv
// Byte-stream front end for the regex matchers: FIFO-buffers {last,char} beats and runs the
// per-character reset/ready handshake with the matcher, reporting matches and end-of-stream.

// Generic synchronous FIFO with pointer-extension full/empty detection.
// Latency: push at t is poppable at t+1 (no bypass); push ignored when full, pop ignored when empty.
module regex_char_feeder_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push   = push_i && !full_o;
    assign do_pop    = pop_i && !empty_o;
    assign pop_dat_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: pointers alone define which entries are live.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
        end
    end
endmodule

// Per-char matcher sequencer: IDLE(pop) -> LOAD(m_rst held) -> WAIT(m_rdy/timeout) -> CAPTURE.
// Latency: min 1+RST_CYCLES+2+1 cycles per beat; in_ready_o drops only when the FIFO is full.
module regex_char_feeder #(
    parameter int DEPTH      = 8,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 256
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [7:0]  in_char_i,
    input  logic        in_last_i,
    output logic        m_rst_o,
    output logic [7:0]  m_char_o,
    output logic        m_last_o,
    input  logic        m_rdy_i,
    input  logic        m_match_i,
    input  logic [31:0] m_start_pos_i,
    input  logic [31:0] m_end_pos_i,
    output logic        res_valid_o,
    output logic [31:0] res_start_o,
    output logic [31:0] res_end_o,
    output logic [31:0] char_count_o,
    output logic        done_o,
    output logic        busy_o,
    output logic        timeout_err_o
);
    typedef struct packed {
        logic       last;
        logic [7:0] chr;
    } beat_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_CAPTURE
    } state_t;

    localparam int LOAD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [LOAD_W-1:0] LOAD_LAST = LOAD_W'(RST_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    beat_t in_beat, head_beat;
    logic  fifo_full, fifo_empty, fifo_pop;

    state_t             state_q, state_d;
    logic [LOAD_W-1:0]  load_cnt_q, load_cnt_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [7:0]         m_char_q, m_char_d;
    logic               m_last_q, m_last_d;
    logic               match_q, match_d;
    logic [31:0]        samp_start_q, samp_start_d;
    logic [31:0]        samp_end_q, samp_end_d;
    logic               res_valid_q, res_valid_d;
    logic [31:0]        res_start_q, res_start_d;
    logic [31:0]        res_end_q, res_end_d;
    logic [31:0]        char_count_q, char_count_d;
    logic               done_q, done_d;
    logic               timeout_err_q, timeout_err_d;

    assign in_beat = '{last: in_last_i, chr: in_char_i};

    regex_char_feeder_fifo #(
        .WIDTH ($bits(beat_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (in_valid_i),
        .push_dat_i (in_beat),
        .pop_i      (fifo_pop),
        .pop_dat_o  (head_beat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    always_comb begin
        state_d       = state_q;
        load_cnt_d    = load_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        m_char_d      = m_char_q;
        m_last_d      = m_last_q;
        match_d       = match_q;
        samp_start_d  = samp_start_q;
        samp_end_d    = samp_end_q;
        res_valid_d   = 1'b0;
        res_start_d   = res_start_q;
        res_end_d     = res_end_q;
        done_d        = 1'b0;
        // The count stays visible during the done strobe and clears right after it.
        char_count_d  = done_q ? 32'd0 : char_count_q;
        timeout_err_d = timeout_err_q;
        fifo_pop      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    m_char_d   = head_beat.chr;
                    m_last_d   = head_beat.last;
                    load_cnt_d = '0;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                if (load_cnt_q == LOAD_LAST) begin
                    wait_cnt_d = '0;
                    state_d    = S_WAIT;
                end else begin
                    load_cnt_d = load_cnt_q + LOAD_W'(1);
                end
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                // m_rdy in the first WAIT cycle may still belong to the previous char.
                if ((wait_cnt_q != '0) && m_rdy_i) begin
                    match_d      = m_match_i;
                    samp_start_d = m_start_pos_i;
                    samp_end_d   = m_end_pos_i;
                    state_d      = S_CAPTURE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    match_d       = 1'b0;
                    timeout_err_d = 1'b1;
                    state_d       = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (match_q) begin
                    res_valid_d = 1'b1;
                    res_start_d = samp_start_q;
                    res_end_d   = samp_end_q;
                end
                if (m_last_q) begin
                    done_d = 1'b1;
                end else begin
                    char_count_d = char_count_q + 32'd1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            load_cnt_q    <= '0;
            wait_cnt_q    <= '0;
            m_char_q      <= 8'd0;
            m_last_q      <= 1'b0;
            match_q       <= 1'b0;
            samp_start_q  <= 32'd0;
            samp_end_q    <= 32'd0;
            res_valid_q   <= 1'b0;
            res_start_q   <= 32'd0;
            res_end_q     <= 32'd0;
            char_count_q  <= 32'd0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            load_cnt_q    <= load_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            m_char_q      <= m_char_d;
            m_last_q      <= m_last_d;
            match_q       <= match_d;
            samp_start_q  <= samp_start_d;
            samp_end_q    <= samp_end_d;
            res_valid_q   <= res_valid_d;
            res_start_q   <= res_start_d;
            res_end_q     <= res_end_d;
            char_count_q  <= char_count_d;
            done_q        <= done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign in_ready_o    = !fifo_full;
    assign m_rst_o       = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign m_char_o      = m_char_q;
    assign m_last_o      = m_last_q;
    assign res_valid_o   = res_valid_q;
    assign res_start_o   = res_start_q;
    assign res_end_o     = res_end_q;
    assign char_count_o  = char_count_q;
    assign done_o        = done_q;
    assign busy_o        = (state_q != S_IDLE) || !fifo_empty;
    assign timeout_err_o = timeout_err_q;
endmodule

// File: tb/tb_regex_char_feeder.sv
// Directed bench for regex_char_feeder with a small behavioural matcher and a handshake monitor.
module tb_regex_char_feeder;
    logic        clk, rst_n;
    logic        in_valid, in_ready, in_last;
    logic [7:0]  in_char;
    logic        m_rst, m_last, m_rdy, m_match;
    logic [7:0]  m_char;
    logic [31:0] m_start, m_end;
    logic        res_valid, done, busy, timeout_err;
    logic [31:0] res_start, res_end, char_count;

    int cmp_cnt = 0;
    int err_cnt = 0;

    // matcher model controls: 0 = rdy 3 cycles after m_rst falls, 1 = always rdy,
    // 2 = never rdy, 3 = not rdy until the FIFO has been seen full, then rdy
    int          rdy_mode = 0;
    bit          match_en = 0;
    logic [7:0]  match_chr = 8'h00;
    logic [31:0] start_v = 32'd0, end_v = 32'd0;
    int          low_cnt = 0;
    bit          full_seen = 0;

    bit          prev_rst = 1'b1;
    logic [7:0]  prev_chr = 8'h00;
    int          hi_run = 0, low_run = 0;
    logic [7:0]  q_chr[$];
    logic        q_last[$];
    int          q_hi[$];
    int          q_low[$];
    int          res_cnt = 0, done_cnt = 0, both_cnt = 0;
    logic [31:0] res_s = 32'd0, res_e = 32'd0, done_cc = 32'd0;

    int push_total = 0, stall_at = -1, push_lost = 0;

    regex_char_feeder #(.DEPTH(8), .RST_CYCLES(2), .TIMEOUT(16)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_char_i(in_char), .in_last_i(in_last),
        .m_rst_o(m_rst), .m_char_o(m_char), .m_last_o(m_last),
        .m_rdy_i(m_rdy), .m_match_i(m_match), .m_start_pos_i(m_start), .m_end_pos_i(m_end),
        .res_valid_o(res_valid), .res_start_o(res_start), .res_end_o(res_end),
        .char_count_o(char_count), .done_o(done), .busy_o(busy), .timeout_err_o(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1);
    end

    // Matcher model, updated away from the active edge.
    initial begin
        m_rdy = 1'b0; m_match = 1'b0; m_start = 32'd0; m_end = 32'd0;
        forever begin
            @(negedge clk);
            if (m_rst) low_cnt = 0; else low_cnt++;
            if (rdy_mode != 3) full_seen = 0;
            else if (!in_ready) full_seen = 1;
            case (rdy_mode)
                0:       m_rdy = (low_cnt >= 3);
                1:       m_rdy = 1'b1;
                3:       m_rdy = full_seen;
                default: m_rdy = 1'b0;
            endcase
            m_match = match_en && (m_char == match_chr);
            m_start = start_v;
            m_end   = end_v;
        end
    end

    // Handshake monitor: logs each beat at m_rst fall and strobe activity.
    always @(negedge clk) begin
        if (m_rst) begin
            if (!prev_rst) q_low.push_back(low_run);
            if (prev_rst && m_char == prev_chr) hi_run++; else hi_run = 1;
        end else begin
            if (prev_rst) begin
                q_chr.push_back(m_char);
                q_last.push_back(m_last);
                q_hi.push_back(hi_run);
                low_run = 0;
            end
            low_run++;
        end
        prev_rst = m_rst;
        prev_chr = m_char;
        if (res_valid) begin res_cnt++; res_s = res_start; res_e = res_end; end
        if (done) begin
            done_cnt++;
            done_cc = char_count;
            if (res_valid) both_cnt++;
        end
    end

    function automatic logic [79:0] chars_from(int base, int n);
        logic [79:0] v = '0;
        for (int i = 0; i < n; i++) v = {v[71:0], (base + i < q_chr.size()) ? q_chr[base + i] : 8'hxx};
        return v;
    endfunction

    function automatic logic [9:0] lasts_from(int base, int n);
        logic [9:0] v = '0;
        for (int i = 0; i < n; i++) v = {v[8:0], (base + i < q_last.size()) ? q_last[base + i] : 1'bx};
        return v;
    endfunction

    task automatic do_reset;
        in_valid = 1'b0; in_last = 1'b0; in_char = 8'h00;
        @(negedge clk); rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic push_beat(input logic [7:0] ch, input logic last);
        int  n  = 0;
        bit  ok = 0;
        @(negedge clk);
        in_valid = 1'b1; in_char = ch; in_last = last;
        while (!ok && n < 300) begin
            if (in_ready) ok = 1;
            else if (stall_at < 0) stall_at = push_total;
            @(posedge clk);
            n++;
            if (!ok) @(negedge clk);
        end
        if (ok) push_total++; else push_lost++;
    endtask

    task automatic idle_in;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        int n = 0;
        @(negedge clk);
        while (busy && n < 2000) begin @(negedge clk); n++; end
        ok = !busy && (push_lost == 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [110:0] got;
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_char = 8'h00;
        #3;
        got = {in_ready, m_rst, m_char, m_last, res_valid, res_start, res_end, char_count, done, busy, timeout_err};
        cmp_cnt++;
        if (got !== {1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 96'h0, 1'b0, 1'b0, 1'b0}) begin
            err_cnt++; $display("FAIL reset_values: got %h required %h", got, {1'b1, 1'b1, 109'h0});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cmp_cnt++;
        if ({busy, m_rst, in_ready} !== 3'b011) begin
            err_cnt++; $display("FAIL reset_release_idle: busy,m_rst,in_ready got %b required 011", {busy, m_rst, in_ready});
        end
    endtask

    task automatic test_no_match_stream;
        int bf, bd, br; bit ok;
        do_reset; rdy_mode = 0; match_en = 0;
        bf = q_chr.size(); bd = done_cnt; br = res_cnt;
        push_beat(8'h61, 0); push_beat(8'h62, 0); push_beat(8'h7a, 1); idle_in;
        wait_idle(ok);
        cmp_cnt++;
        if (!ok) begin err_cnt++; $display("FAIL t1_idle: busy=%b lost=%0d, required idle and no lost push", busy, push_lost); end
        cmp_cnt++;
        if (q_chr.size() - bf != 3) begin err_cnt++; $display("FAIL t1_load_phases: got %0d required 3", q_chr.size() - bf); end
        cmp_cnt++;
        if (chars_from(bf, 3) !== 80'h61627a) begin err_cnt++; $display("FAIL t1_chars: got %h required 61627a", chars_from(bf, 3)); end
        cmp_cnt++;
        if (lasts_from(bf, 3) !== 10'b001) begin err_cnt++; $display("FAIL t1_lasts: got %b required 001", lasts_from(bf, 3)); end
        cmp_cnt++;
        if (done_cnt - bd != 1 || done_cc !== 32'd2) begin
            err_cnt++; $display("FAIL t1_done: count %0d char_count %0d, required 1 and 2", done_cnt - bd, done_cc);
        end
        cmp_cnt++;
        if (res_cnt != br) begin err_cnt++; $display("FAIL t1_no_res: got %0d res_valid, required 0", res_cnt - br); end
        cmp_cnt++;
        if (char_count !== 32'd0) begin err_cnt++; $display("FAIL t1_count_clear: got %0d required 0", char_count); end
    endtask

    task automatic test_match;
        int bd, br; bit ok;
        do_reset; rdy_mode = 0; match_en = 1; match_chr = 8'h62; start_v = 32'd1; end_v = 32'd1;
        bd = done_cnt; br = res_cnt;
        push_beat(8'h61, 0); push_beat(8'h62, 0); push_beat(8'h63, 0); push_beat(8'h64, 1); idle_in;
        wait_idle(ok);
        start_v = 32'd77; end_v = 32'd88;
        cmp_cnt++;
        if (!ok) begin err_cnt++; $display("FAIL t2_idle: busy=%b lost=%0d, required idle", busy, push_lost); end
        cmp_cnt++;
        if (res_cnt - br != 1 || res_s !== 32'd1 || res_e !== 32'd1) begin
            err_cnt++; $display("FAIL t2_res: %0d strobes start %0d end %0d, required 1,1,1", res_cnt - br, res_s, res_e);
        end
        cmp_cnt++;
        if (res_start !== 32'd1 || res_end !== 32'd1) begin
            err_cnt++; $display("FAIL t2_res_held: start %0d end %0d, required 1 1", res_start, res_end);
        end
        cmp_cnt++;
        if (done_cnt - bd != 1 || done_cc !== 32'd3) begin
            err_cnt++; $display("FAIL t2_done: count %0d char_count %0d, required 1 and 3", done_cnt - bd, done_cc);
        end
    endtask

    task automatic test_match_on_last;
        int bd, br, bb; bit ok;
        do_reset; rdy_mode = 0; match_en = 1; match_chr = 8'h66; start_v = 32'd5; end_v = 32'd9;
        bd = done_cnt; br = res_cnt; bb = both_cnt;
        push_beat(8'h65, 0); push_beat(8'h66, 1); idle_in;
        wait_idle(ok);
        cmp_cnt++;
        if (!ok) begin err_cnt++; $display("FAIL t2b_idle: busy=%b lost=%0d, required idle", busy, push_lost); end
        cmp_cnt++;
        if (res_cnt - br != 1 || both_cnt - bb != 1 || done_cnt - bd != 1) begin
            err_cnt++; $display("FAIL t2b_res_with_done: res %0d same-cycle %0d done %0d, required 1 1 1", res_cnt - br, both_cnt - bb, done_cnt - bd);
        end
        cmp_cnt++;
        if (res_start !== 32'd5 || res_end !== 32'd9 || done_cc !== 32'd1) begin
            err_cnt++; $display("FAIL t2b_values: start %0d end %0d count %0d, required 5 9 1", res_start, res_end, done_cc);
        end
    endtask

    task automatic test_empty_stream;
        int bf, bd, br; bit ok;
        do_reset; rdy_mode = 0; match_en = 0;
        bf = q_chr.size(); bd = done_cnt; br = res_cnt;
        push_beat(8'h7a, 1); idle_in;
        wait_idle(ok);
        cmp_cnt++;
        if (!ok || q_chr.size() - bf != 1) begin
            err_cnt++; $display("FAIL te_beats: idle=%b beats %0d, required idle and 1", ok, q_chr.size() - bf);
        end
        cmp_cnt++;
        if (done_cnt - bd != 1 || done_cc !== 32'd0 || res_cnt != br) begin
            err_cnt++; $display("FAIL te_done: done %0d count %0d res %0d, required 1 0 0", done_cnt - bd, done_cc, res_cnt - br);
        end
    endtask

    task automatic test_back_to_back;
        int bf; bit ok;
        do_reset; rdy_mode = 3; match_en = 0;
        bf = q_chr.size(); push_total = 0; stall_at = -1;
        for (int i = 0; i < 10; i++) push_beat(8'h30 + 8'(i), 0);
        idle_in;
        rdy_mode = 1;
        wait_idle(ok);
        cmp_cnt++;
        if (!ok) begin err_cnt++; $display("FAIL t3_idle: busy=%b lost=%0d, required idle", busy, push_lost); end
        cmp_cnt++;
        if (stall_at != 9) begin err_cnt++; $display("FAIL t3_first_stall: after %0d accepted, required 9", stall_at); end
        cmp_cnt++;
        if (q_chr.size() - bf != 10 || chars_from(bf, 10) !== 80'h30313233343536373839) begin
            err_cnt++; $display("FAIL t3_order: %0d beats %h, required 10 beats 30..39", q_chr.size() - bf, chars_from(bf, 10));
        end
        cmp_cnt++;
        if (char_count !== 32'd10 || timeout_err !== 1'b0) begin
            err_cnt++; $display("FAIL t3_count: char_count %0d timeout_err %b, required 10 0", char_count, timeout_err);
        end
    endtask

    task automatic test_rdy_always;
        int bf, bl; bit ok;
        do_reset; rdy_mode = 1; match_en = 0;
        bf = q_hi.size(); bl = q_low.size();
        push_beat(8'h78, 0); push_beat(8'h79, 0); push_beat(8'h7a, 0); idle_in;
        wait_idle(ok);
        cmp_cnt++;
        if (!ok || q_hi.size() - bf != 3 || q_low.size() - bl != 3) begin
            err_cnt++; $display("FAIL t4_beats: idle=%b falls %0d rises %0d, required 3 3", ok, q_hi.size() - bf, q_low.size() - bl);
        end
        for (int i = 0; i < 3; i++) begin
            cmp_cnt++;
            if (bf + i >= q_hi.size() || q_hi[bf + i] != 2) begin
                err_cnt++; $display("FAIL t4_rst_cycles[%0d]: got %0d required 2", i, (bf + i < q_hi.size()) ? q_hi[bf + i] : -1);
            end
            cmp_cnt++;
            if (bl + i >= q_low.size() || q_low[bl + i] != 3) begin
                err_cnt++; $display("FAIL t4_low_cycles[%0d]: got %0d required 3", i, (bl + i < q_low.size()) ? q_low[bl + i] : -1);
            end
        end
    endtask

    task automatic test_timeout;
        int bl, bd, br, n; bit ok;
        do_reset; rdy_mode = 2; match_en = 1; match_chr = 8'h6b; start_v = 32'd3; end_v = 32'd4;
        bl = q_low.size(); bd = done_cnt; br = res_cnt;
        push_beat(8'h6b, 0); push_beat(8'h6c, 0); push_beat(8'h6d, 1); idle_in;
        n = 0;
        do begin @(negedge clk); n++; end while (m_rst && n < 100);
        n = 1;
        while (!timeout_err && n < 100) begin @(negedge clk); n++; end
        cmp_cnt++;
        if (n != 17) begin err_cnt++; $display("FAIL t5_timeout_cycle: err seen at low cycle %0d, required 17", n); end
        wait_idle(ok);
        cmp_cnt++;
        if (!ok || done_cnt - bd != 1 || done_cc !== 32'd2) begin
            err_cnt++; $display("FAIL t5_stream: idle=%b done %0d count %0d, required 1 1 2", ok, done_cnt - bd, done_cc);
        end
        cmp_cnt++;
        if (res_cnt != br || timeout_err !== 1'b1) begin
            err_cnt++; $display("FAIL t5_sticky: res %0d timeout_err %b, required 0 1", res_cnt - br, timeout_err);
        end
        cmp_cnt++;
        if (q_low.size() - bl != 3 || q_low[bl] != 17 || q_low[bl + 2] != 17) begin
            err_cnt++; $display("FAIL t5_low_cycles: %0d beats first %0d, required 3 beats of 17", q_low.size() - bl, q_low[bl]);
        end
    endtask

    task automatic test_async_reset;
        int bf, bd, n; bit ok;
        logic [110:0] got;
        do_reset; rdy_mode = 0; match_en = 0;
        push_beat(8'h72, 0); push_beat(8'h73, 0); push_beat(8'h74, 0); idle_in;
        n = 0;
        while (m_rst && n < 100) begin @(negedge clk); n++; end
        #2 rst_n = 1'b0;
        #1;
        got = {in_ready, m_rst, m_char, m_last, res_valid, res_start, res_end, char_count, done, busy, timeout_err};
        cmp_cnt++;
        if (n >= 100 || got !== {1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 96'h0, 1'b0, 1'b0, 1'b0}) begin
            err_cnt++; $display("FAIL t6_async_values: got %h required %h (wait %0d)", got, {1'b1, 1'b1, 109'h0}, n);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cmp_cnt++;
        if (busy !== 1'b0) begin err_cnt++; $display("FAIL t6_fifo_flushed: busy %b required 0", busy); end
        bf = q_chr.size(); bd = done_cnt;
        push_beat(8'h70, 0); push_beat(8'h71, 1); idle_in;
        wait_idle(ok);
        cmp_cnt++;
        if (!ok || q_chr.size() - bf != 2 || chars_from(bf, 2) !== 80'h7071) begin
            err_cnt++; $display("FAIL t6_new_stream: idle=%b beats %0d chars %h, required 2 beats 7071", ok, q_chr.size() - bf, chars_from(bf, 2));
        end
        cmp_cnt++;
        if (done_cnt - bd != 1 || done_cc !== 32'd1 || timeout_err !== 1'b0) begin
            err_cnt++; $display("FAIL t6_done: done %0d count %0d terr %b, required 1 1 0", done_cnt - bd, done_cc, timeout_err);
        end
    endtask

    initial begin
        test_reset;
        test_no_match_stream;
        test_match;
        test_match_on_last;
        test_empty_stream;
        test_back_to_back;
        test_rdy_always;
        test_timeout;
        test_async_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
